// File: rtl/pio_word_bridge.sv
`default_nettype none
// ============================================================================
// Module   : pio_word_bridge
// Purpose  : Bridges a narrow, handshaked software PIO channel to a wide
//            valid/ready word interface on the hardware core. Software writes
//            BEATS beats that are assembled little-endian into in_word. The
//            core's result words are buffered, and software reads them back
//            beat by beat.
// Ports    : clk_clk      - clock, rising edge
//            reset_reset  - asynchronous active-high reset
//            to_hw_port   - software beat in (DATA_W)
//            to_hw_sig    - software command: 00 idle, 01 write, 10 read,
//                           11 abort
//            to_sw_port   - result beat out (DATA_W), zero outside a read ack
//            to_sw_sig    - status: 00 idle, 01 ack, 10 result ready,
//                           11 error
//            in_word/in_valid/in_ready     - assembled word to the core
//            out_word/out_valid/out_ready  - result word from the core
// Revision : 1.0 - initial release
// ============================================================================
module pio_word_bridge #(
  parameter int DATA_W = 8,
  parameter int WORD_W = 128
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [DATA_W-1:0] to_hw_port,
  input  logic [1:0]        to_hw_sig,
  output logic [DATA_W-1:0] to_sw_port,
  output logic [1:0]        to_sw_sig,
  output logic [WORD_W-1:0] in_word,
  output logic              in_valid,
  input  logic              in_ready,
  input  logic [WORD_W-1:0] out_word,
  input  logic              out_valid,
  output logic              out_ready
);

  localparam int c_BEATS = WORD_W / DATA_W;
  localparam int c_CNT_W = $clog2(c_BEATS);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_BEATS - 1);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

  localparam logic [1:0] c_CMD_IDLE  = 2'b00;
  localparam logic [1:0] c_CMD_WRITE = 2'b01;
  localparam logic [1:0] c_CMD_READ  = 2'b10;
  localparam logic [1:0] c_CMD_ABORT = 2'b11;

  localparam logic [1:0] c_STS_IDLE   = 2'b00;
  localparam logic [1:0] c_STS_ACK    = 2'b01;
  localparam logic [1:0] c_STS_RESULT = 2'b10;
  localparam logic [1:0] c_STS_ERROR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ACK  = 3'd1,
    S_DELIVER = 3'd2,
    S_RD_ACK  = 3'd3,
    S_ABORT   = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_wcnt;
  logic [c_CNT_W-1:0]   r_rcnt;
  logic                 r_res_full;
  logic [WORD_W-1:0]    r_res;
  logic [WORD_W-1:0]    r_in_word;

  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   w_wcnt_nxt;
  logic [c_CNT_W-1:0]   w_rcnt_nxt;
  logic                 w_res_clr;
  logic                 w_beat_we;
  logic                 w_capture;

  // The result buffer fills whenever it is empty, regardless of FSM state.
  // A read completing on the same edge still sees r_res_full=1, so the
  // capture naturally slips to the following cycle.
  assign w_capture = out_valid & ~r_res_full;
  assign out_ready = ~r_res_full;
  assign in_word   = r_in_word;

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_rcnt_nxt  = r_rcnt;
    w_res_clr   = 1'b0;
    w_beat_we   = 1'b0;
    in_valid    = 1'b0;
    to_sw_sig   = c_STS_IDLE;
    to_sw_port  = '0;

    // Abort overrides everything, including a word waiting in DELIVER.
    if (to_hw_sig == c_CMD_ABORT) begin
      w_state_nxt = S_ABORT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (to_hw_sig == c_CMD_WRITE) begin
            w_beat_we   = 1'b1;
            w_state_nxt = S_WR_ACK;
          end else if (to_hw_sig == c_CMD_READ) begin
            w_state_nxt = r_res_full ? S_RD_ACK : S_ERR;
          end
        end
        S_WR_ACK: begin
          if (to_hw_sig == c_CMD_IDLE) begin
            if (r_wcnt == c_LAST) begin
              w_wcnt_nxt  = '0;
              w_state_nxt = S_DELIVER;
            end else begin
              w_wcnt_nxt  = r_wcnt + c_ONE;
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_DELIVER: begin
          if (in_ready) begin
            w_state_nxt = S_IDLE;
          end
        end
        S_RD_ACK: begin
          if (to_hw_sig == c_CMD_IDLE) begin
            if (r_rcnt == c_LAST) begin
              w_rcnt_nxt = '0;
              w_res_clr  = 1'b1;
            end else begin
              w_rcnt_nxt = r_rcnt + c_ONE;
            end
            w_state_nxt = S_IDLE;
          end
        end
        S_ABORT: begin
          if (to_hw_sig == c_CMD_IDLE) begin
            w_wcnt_nxt  = '0;
            w_rcnt_nxt  = '0;
            w_res_clr   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_ERR: begin
          w_state_nxt = S_ERR;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    case (r_state)
      S_IDLE:    to_sw_sig = r_res_full ? c_STS_RESULT : c_STS_IDLE;
      S_WR_ACK:  to_sw_sig = c_STS_ACK;
      S_RD_ACK:  to_sw_sig = c_STS_ACK;
      S_ABORT:   to_sw_sig = c_STS_ACK;
      S_ERR:     to_sw_sig = c_STS_ERROR;
      default:   to_sw_sig = c_STS_IDLE;
    endcase

    in_valid = (r_state == S_DELIVER);

    if (r_state == S_RD_ACK) begin
      for (int k = 0; k < c_BEATS; k++) begin
        if (r_rcnt == c_CNT_W'(k)) begin
          to_sw_port = r_res[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state    <= S_IDLE;
      r_wcnt     <= '0;
      r_rcnt     <= '0;
      r_res_full <= 1'b0;
      r_res      <= '0;
      r_in_word  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_rcnt  <= w_rcnt_nxt;

      if (w_capture) begin
        r_res      <= out_word;
        r_res_full <= 1'b1;
      end else if (w_res_clr) begin
        r_res_full <= 1'b0;
      end

      // Little-endian assembly: beat k lands in bits [k*DATA_W +: DATA_W].
      if (w_beat_we) begin
        for (int k = 0; k < c_BEATS; k++) begin
          if (r_wcnt == c_CNT_W'(k)) begin
            r_in_word[k*DATA_W +: DATA_W] <= to_hw_port;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pio_word_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_pio_word_bridge
// Purpose  : Self-checking bench for pio_word_bridge (DATA_W=8, WORD_W=32).
//            Stimulus pushes expected words/beats into queues; a monitor on
//            the opposite clock edge pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pio_word_bridge;

  localparam int DATA_W = 8;
  localparam int WORD_W = 32;

  logic              clk_clk = 1'b0;
  logic              reset_reset;
  logic [DATA_W-1:0] to_hw_port;
  logic [1:0]        to_hw_sig;
  logic [DATA_W-1:0] to_sw_port;
  logic [1:0]        to_sw_sig;
  logic [WORD_W-1:0] in_word;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] out_word;
  logic              out_valid;
  logic              out_ready;

  pio_word_bridge #(
    .DATA_W (DATA_W),
    .WORD_W (WORD_W)
  ) u_dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .to_hw_port  (to_hw_port),
    .to_hw_sig   (to_hw_sig),
    .to_sw_port  (to_sw_port),
    .to_sw_sig   (to_sw_sig),
    .in_word     (in_word),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_word    (out_word),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk_clk = ~clk_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] q_word[$];
  logic [7:0]  q_beat[$];
  logic        mon_rd_now;
  logic        mon_rd_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: checks every presented word and the first cycle of every read ack.
  always @(negedge clk_clk) begin
    if (!reset_reset) begin
      if (in_valid) begin
        if (q_word.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL in_word_unexpected actual=0x%0h required=none", in_word);
        end else begin
          chk("in_word", in_word, q_word[0]);
          if (in_ready) void'(q_word.pop_front());
        end
      end
      mon_rd_now = (to_hw_sig == 2'b10) && (to_sw_sig == 2'b01);
      if (mon_rd_now && !mon_rd_prev) begin
        if (q_beat.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_beat_unexpected actual=0x%0h required=none", to_sw_port);
        end else begin
          chk("rd_beat", {24'h0, to_sw_port}, {24'h0, q_beat.pop_front()});
        end
      end
      mon_rd_prev = mon_rd_now;
    end else begin
      mon_rd_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic wait_sig(input logic [1:0] v, input string name);
    int n = 0;
    while (to_sw_sig !== v && n < 20) begin
      tick();
      n++;
    end
    chk(name, {30'h0, to_sw_sig}, {30'h0, v});
  endtask

  task automatic sw_write(input logic [7:0] b);
    to_hw_port = b;
    to_hw_sig  = 2'b01;
    tick();
    wait_sig(2'b01, "wr_ack");
    tick();
    to_hw_sig = 2'b00;
    tick();
  endtask

  task automatic sw_read();
    to_hw_sig = 2'b10;
    tick();
    wait_sig(2'b01, "rd_ack");
    tick();
    to_hw_sig = 2'b00;
    tick();
  endtask

  task automatic write_word(input logic [31:0] w);
    q_word.push_back(w);
    for (int k = 0; k < 4; k++) sw_write(w[k*8 +: 8]);
  endtask

  task automatic drain();
    int n = 0;
    while (in_valid && n < 20) begin
      tick();
      n++;
    end
    chk("drain", {31'h0, in_valid}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset_reset = 1'b1;
    to_hw_port  = '0;
    to_hw_sig   = 2'b00;
    in_ready    = 1'b0;
    out_word    = '0;
    out_valid   = 1'b0;
    repeat (3) tick();
    chk("rst_sig",      {30'h0, to_sw_sig}, 32'h0);
    chk("rst_out_rdy",  {31'h0, out_ready}, 32'h1);
    chk("rst_in_valid", {31'h0, in_valid},  32'h0);
    chk("rst_port",     {24'h0, to_sw_port}, 32'h0);
    chk("rst_in_word",  in_word, 32'h0);
    reset_reset = 1'b0;
    tick();

    // Word assembly with the core stalling, WRITE ignored while delivering.
    write_word(32'h44332211);
    chk("deliver_valid", {31'h0, in_valid}, 32'h1);
    chk("deliver_sig",   {30'h0, to_sw_sig}, 32'h0);
    to_hw_port = 8'h99;
    to_hw_sig  = 2'b01;
    repeat (2) tick();
    to_hw_sig = 2'b00;
    repeat (3) tick();
    chk("deliver_hold", {31'h0, in_valid}, 32'h1);
    in_ready = 1'b1;
    tick();
    chk("deliver_done", {31'h0, in_valid}, 32'h0);

    // Result readback, then a second result queued on the final read beat.
    out_word  = 32'hDEADBEEF;
    out_valid = 1'b1;
    tick();
    out_valid = 1'b0;
    chk("res_out_rdy", {31'h0, out_ready}, 32'h0);
    chk("res_sig",     {30'h0, to_sw_sig}, 32'h2);
    q_beat.push_back(8'hEF);
    q_beat.push_back(8'hBE);
    q_beat.push_back(8'hAD);
    repeat (3) sw_read();
    out_word  = 32'hCAFEF00D;
    out_valid = 1'b1;
    q_beat.push_back(8'hDE);
    sw_read();
    chk("no_same_cycle_capture", {31'h0, out_ready}, 32'h1);
    tick();
    out_valid = 1'b0;
    chk("late_capture_rdy", {31'h0, out_ready}, 32'h0);
    chk("late_capture_sig", {30'h0, to_sw_sig}, 32'h2);
    q_beat.push_back(8'h0D);
    q_beat.push_back(8'hF0);
    q_beat.push_back(8'hFE);
    q_beat.push_back(8'hCA);
    repeat (4) sw_read();
    chk("res_empty_rdy", {31'h0, out_ready}, 32'h1);
    chk("res_empty_sig", {30'h0, to_sw_sig}, 32'h0);

    // Read without a result -> error, sticky until abort.
    to_hw_sig = 2'b10;
    tick();
    chk("err_sig", {30'h0, to_sw_sig}, 32'h3);
    tick();
    to_hw_sig = 2'b00;
    tick();
    chk("err_hold", {30'h0, to_sw_sig}, 32'h3);
    to_hw_sig = 2'b11;
    tick();
    chk("err_abort_ack", {30'h0, to_sw_sig}, 32'h1);
    to_hw_sig = 2'b00;
    tick();
    chk("err_cleared", {30'h0, to_sw_sig}, 32'h0);
    write_word(32'h04030201);
    drain();

    // Abort after two beats restarts assembly at beat 0.
    sw_write(8'h55);
    sw_write(8'h66);
    to_hw_sig = 2'b11;
    tick();
    chk("abort_ack", {30'h0, to_sw_sig}, 32'h1);
    to_hw_sig = 2'b00;
    tick();
    chk("abort_idle", {30'h0, to_sw_sig}, 32'h0);
    write_word(32'hA3A2A1A0);
    drain();

    // WRITE held in WR_ACK must not advance the beat counter.
    q_word.push_back(32'h7A797877);
    to_hw_port = 8'h77;
    to_hw_sig  = 2'b01;
    tick();
    repeat (10) tick();
    chk("wr_ack_hold", {30'h0, to_sw_sig}, 32'h1);
    to_hw_sig = 2'b00;
    tick();
    chk("wr_ack_release", {30'h0, to_sw_sig}, 32'h0);
    sw_write(8'h78);
    sw_write(8'h79);
    sw_write(8'h7A);
    drain();

    // Asynchronous reset in the middle of a read acknowledge.
    out_word  = 32'h12345678;
    out_valid = 1'b1;
    tick();
    out_valid = 1'b0;
    q_beat.push_back(8'h78);
    to_hw_sig = 2'b10;
    tick();
    chk("pre_rst_ack", {30'h0, to_sw_sig}, 32'h1);
    @(negedge clk_clk);
    #1;
    reset_reset = 1'b1;
    #1;
    chk("async_rst_sig",     {30'h0, to_sw_sig}, 32'h0);
    chk("async_rst_out_rdy", {31'h0, out_ready}, 32'h1);
    chk("async_rst_port",    {24'h0, to_sw_port}, 32'h0);
    chk("async_rst_in_word", in_word, 32'h0);
    to_hw_sig = 2'b00;
    repeat (2) tick();
    reset_reset = 1'b0;
    tick();
    write_word(32'hB3B2B1B0);
    drain();

    repeat (3) tick();
    chk("word_queue_empty", q_word.size(), 32'h0);
    chk("beat_queue_empty", q_beat.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pio_word_bridge.md
PIO_WORD_BRIDGE -- requirements
Module: pio_word_bridge

Interface
REQ-001 Parameter DATA_W, default 8: width of each software-visible PIO beat.
REQ-002 Parameter WORD_W, default 128: width of the assembled hardware word. WORD_W SHALL be an integer multiple of DATA_W with BEATS = WORD_W/DATA_W >= 2.
REQ-003 clk_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_reset  in  1  asynchronous, active-high reset.
REQ-005 to_hw_port  in  DATA_W  beat written by software.
REQ-006 to_hw_sig  in  2  software command: 00 IDLE, 01 WRITE, 10 READ, 11 ABORT.
REQ-007 to_sw_port  out  DATA_W  result beat returned to software.
REQ-008 to_sw_sig  out  2  hardware status: 00 IDLE, 01 ACK, 10 RESULT_READY, 11 ERROR.
REQ-009 in_word  out  WORD_W  assembled word delivered to the hardware core.
REQ-010 in_valid  out  1  in_word valid.
REQ-011 in_ready  in  1  hardware core accepts in_word.
REQ-012 out_word  in  WORD_W  result word from the hardware core.
REQ-013 out_valid  in  1  out_word valid.
REQ-014 out_ready  out  1  bridge can accept out_word.

Function
REQ-015 Beat order SHALL be little-endian: beat k occupies bits [k*DATA_W +: DATA_W], in both directions.
REQ-016 States: IDLE, WR_ACK, DELIVER, RD_ACK, ABORT, ERR. A write counter wcnt and a read counter rcnt SHALL each be clog2(BEATS) bits wide.
REQ-017 Result buffer: out_ready SHALL equal ~res_full in every state.
REQ-018 When out_valid & out_ready: out_word SHALL be latched and res_full SHALL be set on the next edge, independent of FSM state.
REQ-019 In IDLE:
- to_sw_sig SHALL be 10 if res_full, otherwise 00.
- Command 01: to_hw_port SHALL be latched into beat wcnt of in_word, then go to WR_ACK.
- Command 10 with res_full: go to RD_ACK.
- Command 10 without res_full: go to ERR.
REQ-020 WR_ACK:
- to_sw_sig SHALL be 01.
- When to_hw_sig returns to 00: if wcnt == BEATS-1, clear wcnt and go to DELIVER; otherwise increment wcnt and go to IDLE.
REQ-021 DELIVER:
- in_valid SHALL be 1, to_sw_sig SHALL be 00, and in_word SHALL be held stable.
- On in_ready, go to IDLE the next cycle.
- WRITE and READ commands SHALL be ignored until then.
REQ-022 RD_ACK:
- to_sw_sig SHALL be 01 and to_sw_port SHALL show result beat rcnt.
- When to_hw_sig returns to 00: increment rcnt. On the last beat, clear rcnt and res_full. Then go to IDLE.
REQ-023 ERR: to_sw_sig SHALL be 11 and the FSM SHALL leave only on command 11.
REQ-024 Command 11 in any state SHALL go to ABORT on the next edge.
- ABORT drives to_sw_sig=01.
- When to_hw_sig returns to 00: clear wcnt, rcnt, res_full and in_valid, then go to IDLE.
- A word pending in DELIVER SHALL be discarded.
REQ-025 Commands 01 or 10 seen in WR_ACK or RD_ACK SHALL hold the state; only 00 or 11 advance it.
REQ-026 Simultaneous last-beat read completion and out_valid: the capture SHALL NOT occur in that cycle because out_ready=0; it SHALL occur on the following cycle.
REQ-027 in_valid SHALL be 1 only in DELIVER. to_sw_port SHALL be 0 outside RD_ACK.

Reset
REQ-028 On reset_reset=1, the following SHALL be cleared asynchronously:
- state set to IDLE;
- wcnt, rcnt, res_full, in_word, the result register, to_sw_port and in_valid set to 0;
- to_sw_sig set to 00; out_ready set to 1.
REQ-029 Reset asserted mid-transfer SHALL discard all partial beats. After release, the first WRITE SHALL land in beat 0.

Verification (DATA_W=8, WORD_W=32)
REQ-030 Write beats 0x11, 0x22, 0x33, 0x44, each with a 01->00 handshake -> to_sw_sig=01 during each ACK; in_valid=1 with in_word=0x44332211; holding in_ready=0 for 5 cycles keeps in_word unchanged.
REQ-031 Present out_word=0xDEADBEEF with out_valid -> out_ready drops to 0 and to_sw_sig=10; four READ handshakes return 0xEF, 0xBE, 0xAD, 0xDE; then out_ready=1 and to_sw_sig=00.
REQ-032 READ with no result -> to_sw_sig=11; 11 then 00 -> to_sw_sig=00; a subsequent write starts at beat 0.
REQ-033 ABORT after 2 of 4 write beats -> wcnt cleared; the next 4 beats 0xA0..0xA3 yield in_word=0xA3A2A1A0.
REQ-034 Assert reset_reset during RD_ACK with res_full=1 -> to_sw_sig=00, out_ready=1 and to_sw_port=0 in the same cycle, without a clock edge.
REQ-035 Hold to_hw_sig=01 for 10 cycles in WR_ACK -> state stays WR_ACK and wcnt does not advance.
